mem_ctrl_byte: RTL and testbench

- Responder end of the core-to-memory request interface. The CPU core/ICache side is the initiator, driving rw_flag, addr, write_data and write_mask.
- Accepts one 32-bit word request at a time and serialises it into four accesses on a byte-wide synchronous RAM.
- Reports progress with busy and a one-cycle done pulse.
- Sits between cpu_core and the board RAM.

---
 rtl/mem_ctrl_byte_pkg.sv | 25 ++
 rtl/mem_ctrl_byte.sv | 104 ++++++++++
 tb/tb_mem_ctrl_byte.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_byte_pkg.sv
// Request encodings, interface widths and FSM states shared by the byte-serial
// memory controller and anything that talks to it.
package mem_ctrl_byte_pkg;

    localparam int RW_FLAG_WIDTH = 2;
    localparam int ADDR_WIDTH    = 32;
    localparam int DATA_WIDTH    = 32;
    localparam int MASK_WIDTH    = 4;

    typedef enum logic [1:0] {
        RW_IDLE    = 2'b00,
        RW_READ    = 2'b01,
        RW_WRITE   = 2'b10,
        RW_ILLEGAL = 2'b11
    } rw_flag_e;

    typedef enum logic [2:0] {
        MC_IDLE,
        MC_RD_ISSUE,
        MC_RD_DRAIN,
        MC_WR,
        MC_DONE
    } mc_state_e;

endpackage

// File: rtl/mem_ctrl_byte.sv
// Serialises one 32-bit core request into four little-endian byte accesses on a
// byte-wide synchronous RAM, reporting busy and a one-cycle done pulse.
module mem_ctrl_byte
    import mem_ctrl_byte_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH   = 17,
    parameter int RAM_READ_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [RW_FLAG_WIDTH-1:0]  rw_flag,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]     write_data,
    input  logic [MASK_WIDTH-1:0]     write_mask,
    output logic [DATA_WIDTH-1:0]     read_data,
    output logic                      busy,
    output logic                      done,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic                      ram_we,
    output logic [7:0]                ram_din,
    input  logic [7:0]                ram_dout
);

    mc_state_e                   state, state_next;
    logic [RAM_ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]       data_q;
    logic [MASK_WIDTH-1:0]       mask_q;
    logic [1:0]                  issue_cnt;
    logic [1:0]                  cap_cnt;
    logic [RAM_READ_LATENCY-1:0] valid_sr;
    logic                        issuing;
    logic                        capture;
    logic                        accept;
    logic                        unused_addr_high;

    // Address bits beyond the RAM are deliberately dropped.
    assign unused_addr_high = ^addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH];

    assign issuing = (state == MC_RD_ISSUE) || (state == MC_WR);
    assign capture = valid_sr[RAM_READ_LATENCY-1];
    assign accept  = (state == MC_IDLE) && (state_next != MC_IDLE);
    assign busy    = (state != MC_IDLE);
    assign done    = (state == MC_DONE);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            MC_IDLE: begin
                if (rw_flag == RW_READ)       state_next = MC_RD_ISSUE;
                else if (rw_flag == RW_WRITE) state_next = MC_WR;
            end
            MC_RD_ISSUE: if (issue_cnt == 2'd3)           state_next = MC_RD_DRAIN;
            MC_RD_DRAIN: if (capture && cap_cnt == 2'd3)  state_next = MC_DONE;
            MC_WR:       if (issue_cnt == 2'd3)           state_next = MC_DONE;
            MC_DONE:     state_next = MC_IDLE;
            default:     state_next = MC_IDLE;
        endcase
    end

    // RAM port is combinational from state so the RAM samples each lane at the
    // edge that ends its cycle; rst gates ram_we so an abort writes nothing more.
    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        ram_we   = 1'b0;
        if (issuing) ram_addr = addr_q + RAM_ADDR_WIDTH'(issue_cnt);
        if (state == MC_WR) begin
            ram_din = data_q[{issue_cnt, 3'b000} +: 8];
            ram_we  = mask_q[issue_cnt] & ~rst;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MC_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            mask_q    <= '0;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            valid_sr  <= '0;
            read_data <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q <= addr[RAM_ADDR_WIDTH-1:0];
                data_q <= write_data;
                mask_q <= write_mask;
            end
            if (issuing) issue_cnt <= issue_cnt + 2'd1;
            // Marks which cycles carry a RAM byte, RAM_READ_LATENCY after its issue.
            valid_sr[0] <= (state == MC_RD_ISSUE);
            for (int i = 1; i < RAM_READ_LATENCY; i++) valid_sr[i] <= valid_sr[i-1];
            if (capture) begin
                read_data[{cap_cnt, 3'b000} +: 8] <= ram_dout;
                cap_cnt <= cap_cnt + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl_byte.sv
// Self-checking bench for mem_ctrl_byte: byte RAM model plus a word-level
// reference memory, directed scenarios and randomized traffic.
module tb_mem_ctrl_byte;
    import mem_ctrl_byte_pkg::*;

    localparam int RAW      = 17;
    localparam int LAT      = 1;
    localparam int RAM_SIZE = 1 << RAW;
    localparam int WR_DONE  = 5;
    localparam int RD_DONE  = 5 + LAT;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      rw_flag;
    logic [31:0]     addr;
    logic [31:0]     write_data;
    logic [3:0]      write_mask;
    logic [31:0]     read_data;
    logic            busy;
    logic            done;
    logic [RAW-1:0]  ram_addr;
    logic            ram_we;
    logic [7:0]      ram_din;
    logic [7:0]      ram_dout;

    int checks = 0;
    int errors = 0;

    logic [7:0]     ram     [RAM_SIZE];
    logic [7:0]     ref_mem [RAM_SIZE];
    logic [7:0]     rd_pipe [LAT];
    logic [RAW-1:0] addr_trace [4];
    logic [7:0]     din_trace  [4];
    logic [3:0]     we_trace;
    logic [31:0]    last_rd;

    mem_ctrl_byte #(.RAM_ADDR_WIDTH(RAW), .RAM_READ_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .rw_flag(rw_flag), .addr(addr),
        .write_data(write_data), .write_mask(write_mask), .read_data(read_data),
        .busy(busy), .done(done), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Synchronous byte RAM with LAT cycles of read latency.
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_din;
        rd_pipe[0] <= ram[ram_addr];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_dout = rd_pipe[LAT-1];

    initial begin
        #5ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int byte_index(input logic [31:0] a, input int i);
        return int'((a + 32'(i)) % 32'(RAM_SIZE));
    endfunction

    function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        for (int i = 0; i < 4; i++)
            if (m[i]) ref_mem[byte_index(a, i)] = d[8*i +: 8];
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[byte_index(a, i)];
        return w;
    endfunction

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = ram[byte_index(a, i)];
        return w;
    endfunction

    // Issues one request from IDLE, scrambles the inputs after the accept edge,
    // records the four lane cycles and returns the edge index at which done is seen.
    task automatic run_req(input logic [1:0] flag, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m, output int done_k);
        done_k = -1;
        for (int w = 0; w < 30; w++) begin
            @(negedge clk);
            if (!busy) break;
        end
        rw_flag = flag; addr = a; write_data = d; write_mask = m;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                rw_flag = RW_IDLE; addr = $urandom; write_data = $urandom; write_mask = 4'($urandom);
            end
            if (k <= 4) begin
                addr_trace[k-1] = ram_addr; din_trace[k-1] = ram_din; we_trace[k-1] = ram_we;
            end
            if (done) begin
                done_k = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rw_flag = RW_IDLE; addr = '0; write_data = '0; write_mask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL reset_read_data got %h want 0", read_data); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got %0b want 0", ram_we); end
        checks++; if (ram_addr !== '0) begin errors++; $display("FAIL reset_ram_addr got %h want 0", ram_addr); end
        checks++; if (ram_din !== 8'h0) begin errors++; $display("FAIL reset_ram_din got %h want 0", ram_din); end
        rst = 1'b0;
        last_rd = 32'h0;
    endtask

    task automatic test_write_read();
        int k;
        ref_write(32'h100, 32'hDEADBEEF, 4'hF);
        run_req(RW_WRITE, 32'h100, 32'hDEADBEEF, 4'hF, k);
        checks++; if (k != WR_DONE) begin errors++; $display("FAIL wr_done_cycle got %0d want %0d", k, WR_DONE); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (addr_trace[i] !== RAW'(32'h100 + 32'(i)))
                begin errors++; $display("FAIL wr_lane%0d_addr got %h want %h", i, addr_trace[i], 32'h100 + 32'(i)); end
        end
        checks++;
        if (ram_word(32'h100) !== 32'hDEADBEEF || ram_word(32'h100) !== ref_word(32'h100))
            begin errors++; $display("FAIL wr_ram_bytes got %h want %h", ram_word(32'h100), ref_word(32'h100)); end
        checks++; if (read_data !== last_rd) begin errors++; $display("FAIL wr_keeps_read_data got %h want %h", read_data, last_rd); end

        run_req(RW_READ, 32'h100, $urandom, 4'($urandom), k);
        checks++; if (k != RD_DONE) begin errors++; $display("FAIL rd_done_cycle got %0d want %0d", k, RD_DONE); end
        checks++; if (we_trace !== 4'b0) begin errors++; $display("FAIL rd_ram_we got %b want 0000", we_trace); end
        checks++; if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", read_data); end
        last_rd = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %0b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_done got busy %0b want 0", busy); end
        checks++; if (read_data !== last_rd) begin errors++; $display("FAIL rd_data_held got %h want %h", read_data, last_rd); end
    endtask

    task automatic test_partial_mask();
        int k;
        ref_write(32'h180, 32'hAAAAAAAA, 4'hF);
        run_req(RW_WRITE, 32'h180, 32'hAAAAAAAA, 4'hF, k);
        ref_write(32'h180, 32'h11223344, 4'b0101);
        run_req(RW_WRITE, 32'h180, 32'h11223344, 4'b0101, k);
        checks++; if (k != WR_DONE) begin errors++; $display("FAIL pm_done_cycle got %0d want %0d", k, WR_DONE); end
        checks++; if (we_trace !== 4'b0101) begin errors++; $display("FAIL pm_we_pattern got %b want 0101", we_trace); end
        checks++;
        if (din_trace[0] !== 8'h44 || din_trace[2] !== 8'h22)
            begin errors++; $display("FAIL pm_din got %h/%h want 44/22", din_trace[0], din_trace[2]); end
        run_req(RW_READ, 32'h180, '0, '0, k);
        checks++; if (k != RD_DONE) begin errors++; $display("FAIL pm_rd_done_cycle got %0d want %0d", k, RD_DONE); end
        checks++;
        if (read_data !== 32'hAA22AA44 || read_data !== ref_word(32'h180))
            begin errors++; $display("FAIL pm_read got %h want aa22aa44", read_data); end
        last_rd = read_data;
        ref_write(32'h1C0, 32'h0BADF00D, 4'h0);
        run_req(RW_WRITE, 32'h1C0, 32'h0BADF00D, 4'h0, k);
        checks++; if (k != WR_DONE) begin errors++; $display("FAIL mask0_done_cycle got %0d want %0d", k, WR_DONE); end
        checks++; if (we_trace !== 4'b0) begin errors++; $display("FAIL mask0_we got %b want 0000", we_trace); end
    endtask

    task automatic test_idle_illegal();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            rw_flag = (c < 10) ? RW_ILLEGAL : RW_IDLE;
            addr = $urandom; write_data = $urandom; write_mask = 4'hF;
            @(negedge clk);
            checks++;
            if ({busy, done, ram_we} !== 3'b000)
                begin errors++; $display("FAIL idle_flag%0d busy/done/we got %b want 000", rw_flag, {busy, done, ram_we}); end
        end
        rw_flag = RW_IDLE;
    endtask

    task automatic test_back_to_back();
        int k;
        int done_s[$];
        int idle_run;
        logic [31:0] d;
        d = $urandom;
        ref_write(32'h200, d, 4'hF);
        run_req(RW_WRITE, 32'h200, d, 4'hF, k);
        @(negedge clk);
        rw_flag = RW_READ; addr = 32'h200;
        idle_run = 0;
        for (int s = 0; s < 45; s++) begin
            @(negedge clk);
            if (!busy) idle_run++;
            if (done) begin
                if (done_s.size() > 0) begin
                    checks++;
                    if (idle_run != 1) begin errors++; $display("FAIL b2b_idle_gap got %0d want 1", idle_run); end
                end
                checks++;
                if (read_data !== ref_word(32'h200))
                    begin errors++; $display("FAIL b2b_data got %h want %h", read_data, ref_word(32'h200)); end
                idle_run = 0;
                done_s.push_back(s);
            end
        end
        rw_flag = RW_IDLE;
        last_rd = ref_word(32'h200);
        checks++;
        if (done_s.size() < 5) begin errors++; $display("FAIL b2b_done_count got %0d want >=5", done_s.size()); end
        for (int i = 1; i < done_s.size(); i++) begin
            checks++;
            if (done_s[i] - done_s[i-1] != RD_DONE + 1)
                begin errors++; $display("FAIL b2b_period got %0d want %0d", done_s[i] - done_s[i-1], RD_DONE + 1); end
        end
        for (int w = 0; w < 30; w++) begin
            @(negedge clk);
            if (!busy) break;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain got busy %0b want 0", busy); end
    endtask

    task automatic test_wrap();
        int k;
        logic [31:0] a;
        logic [31:0] d;
        a = 32'h5A5BFFFE;
        d = $urandom;
        ref_write(a, d, 4'hF);
        run_req(RW_WRITE, a, d, 4'hF, k);
        run_req(RW_READ, a, '0, '0, k);
        checks++; if (k != RD_DONE) begin errors++; $display("FAIL wrap_done_cycle got %0d want %0d", k, RD_DONE); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (int'(addr_trace[i]) != byte_index(a, i))
                begin errors++; $display("FAIL wrap_lane%0d_addr got %h want %h", i, addr_trace[i], byte_index(a, i)); end
        end
        checks++;
        if (read_data !== ref_word(a) || read_data !== d)
            begin errors++; $display("FAIL wrap_read got %h want %h", read_data, d); end
        last_rd = read_data;
    endtask

    task automatic test_random();
        int k;
        logic [1:0]  f;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        for (int w = 0; w < 16; w++) begin
            d = $urandom;
            ref_write(32'h400 + 32'(4 * w), d, 4'hF);
            run_req(RW_WRITE, 32'h400 + 32'(4 * w), d, 4'hF, k);
        end
        for (int n = 0; n < 40; n++) begin
            f = 2'($urandom_range(1, 2));
            a = ($urandom & 32'hFFFE_0000) | (32'h400 + 32'($urandom_range(0, 60)));
            d = $urandom;
            m = 4'($urandom);
            run_req(f, a, d, m, k);
            if (f == RW_WRITE) begin
                ref_write(a, d, m);
                checks++; if (k != WR_DONE) begin errors++; $display("FAIL rnd_wr_done got %0d want %0d", k, WR_DONE); end
                checks++;
                if (we_trace !== m) begin errors++; $display("FAIL rnd_wr_we got %b want %b", we_trace, m); end
                checks++;
                if (ram_word(a) !== ref_word(a))
                    begin errors++; $display("FAIL rnd_wr_mem @%h got %h want %h", a, ram_word(a), ref_word(a)); end
                checks++;
                if (read_data !== last_rd) begin errors++; $display("FAIL rnd_wr_rdata got %h want %h", read_data, last_rd); end
            end else begin
                checks++; if (k != RD_DONE) begin errors++; $display("FAIL rnd_rd_done got %0d want %0d", k, RD_DONE); end
                checks++;
                if (read_data !== ref_word(a))
                    begin errors++; $display("FAIL rnd_rd_data @%h got %h want %h", a, read_data, ref_word(a)); end
                last_rd = ref_word(a);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int k;
        logic [31:0] d;
        run_req(RW_READ, 32'h100, '0, '0, k);
        ref_write(32'h300, 32'h55667788, 4'hF);
        run_req(RW_WRITE, 32'h300, 32'h55667788, 4'hF, k);
        d = $urandom | 32'h0101_0101;
        ref_write(32'h300, d, 4'b0011);
        @(negedge clk);
        rw_flag = RW_WRITE; addr = 32'h300; write_data = d; write_mask = 4'hF;
        @(posedge clk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            rw_flag = RW_IDLE;
            if (c == 3) begin
                rst = 1'b1;
                #1;
                checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rstw_we_gated got %0b want 0", ram_we); end
            end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstw_early_done got %0b want 0", done); end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstw_busy got %0b want 0", busy); end
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL rstw_read_data got %h want 0", read_data); end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, ram_we} !== 3'b000)
                begin errors++; $display("FAIL rstw_after busy/done/we got %b want 000", {busy, done, ram_we}); end
        end
        checks++;
        if (ram_word(32'h300) !== ref_word(32'h300))
            begin errors++; $display("FAIL rstw_mem got %h want %h", ram_word(32'h300), ref_word(32'h300)); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_mask();
        test_idle_illegal();
        test_back_to_back();
        test_wrap();
        test_random();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
